// File: rtl/machine_cycle_sequencer_pkg.sv
// machine_cycle_sequencer_pkg: shared control-unit timing constants and sequencer state encoding.
// Rev 1.0
`default_nettype none

package machine_cycle_sequencer_pkg;

    localparam int STEP_W_DEF  = 4;
    localparam int COUNT_W_DEF = 8;

    localparam logic [3:0] T1 = 4'b0001;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T3 = 4'b0100;
    localparam logic [3:0] T4 = 4'b1000;
    localparam logic [7:0] M1 = 8'b0000_0001;

    localparam logic [0:0] SEQ_RUN  = 1'b0;
    localparam logic [0:0] SEQ_HALT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/machine_cycle_sequencer_onehot_rotator.sv
// onehot_rotator: one-hot register that rotates left on enable; load returns it to bit0.
// Rev 1.0
`default_nettype none

module onehot_rotator #(
    parameter int W = 4
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_En,
    input  logic         i_Load,
    output logic [W-1:0] o_Q
);

    localparam logic [W-1:0] BIT0 = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] onehot_q;
    logic [W-1:0] onehot_d;

    // Load has priority so a restart never lands on a rotated value
    always_comb begin
        onehot_d = onehot_q;
        if (i_Load) begin
            onehot_d = BIT0;
        end else if (i_En) begin
            onehot_d = {onehot_q[W-2:0], onehot_q[W-1]};
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            onehot_q <= BIT0;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign o_Q = onehot_q;

endmodule

`default_nettype wire

// File: rtl/machine_cycle_sequencer.sv
// machine_cycle_sequencer: T-state / M-cycle timing generator with stall, HALT and runaway detection.
// Rev 1.0
`default_nettype none

module machine_cycle_sequencer
    import machine_cycle_sequencer_pkg::*;
#(
    parameter int STEP_W  = STEP_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Stall,
    input  logic               i_IR_Fetch,
    input  logic               i_Halt_Req,
    input  logic               i_Wake,
    output logic [STEP_W-1:0]  o_Cycle_Step,
    output logic [COUNT_W-1:0] o_Cycle_Count,
    output logic               o_Active,
    output logic               o_M_End,
    output logic               o_Instr_Start,
    output logic               o_Halted,
    output logic               o_Seq_Error
);

    logic [0:0]         state_q, state_d;
    logic               start_q, start_d;
    logic               err_q,   err_d;
    logic               count_load;
    logic               m_end;
    logic [STEP_W-1:0]  step;
    logic [COUNT_W-1:0] count;

    assign m_end = step[STEP_W-1] & ~i_Stall;

    onehot_rotator #(.W(STEP_W)) u_step (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_En    (~i_Stall),
        .i_Load  (1'b0),
        .o_Q     (step)
    );

    onehot_rotator #(.W(COUNT_W)) u_count (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_En    (m_end),
        .i_Load  (count_load),
        .o_Q     (count)
    );

    // Start pulse survives stalls; otherwise it lives for exactly one advancing clock
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        start_d    = i_Stall ? start_q : 1'b0;
        count_load = 1'b0;
        if (m_end) begin
            case (state_q)
                SEQ_RUN: begin
                    if (i_IR_Fetch) begin
                        count_load = 1'b1;
                        if (i_Halt_Req && !i_Wake) begin
                            state_d = SEQ_HALT;
                        end else begin
                            start_d = 1'b1;
                        end
                    end else if (count[COUNT_W-1]) begin
                        err_d      = 1'b1;
                        count_load = 1'b1;
                        start_d    = 1'b1;
                    end
                end
                SEQ_HALT: begin
                    count_load = 1'b1;
                    if (i_Wake) begin
                        state_d = SEQ_RUN;
                        start_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = SEQ_RUN;
                    count_load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= SEQ_RUN;
            start_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign o_Cycle_Step  = step;
    assign o_Cycle_Count = count;
    assign o_M_End       = m_end;
    assign o_Active      = (state_q == SEQ_RUN);
    assign o_Halted      = (state_q == SEQ_HALT);
    assign o_Instr_Start = start_q;
    assign o_Seq_Error   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_machine_cycle_sequencer.sv
// tb_machine_cycle_sequencer: directed table-driven bench for the machine-cycle sequencer.
// Rev 1.0
`default_nettype none

module tb_machine_cycle_sequencer;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        fetch;
        logic        halt;
        logic        wake;
        logic [16:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n, stall, fetch, halt, wake;
    logic [3:0] step;
    logic [7:0] count;
    logic       active, m_end, start, halted, err;

    int   n_checks;
    int   n_pass;
    vec_t vecs[$];

    machine_cycle_sequencer #(.STEP_W(4), .COUNT_W(8)) dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Stall       (stall),
        .i_IR_Fetch    (fetch),
        .i_Halt_Req    (halt),
        .i_Wake        (wake),
        .o_Cycle_Step  (step),
        .o_Cycle_Count (count),
        .o_Active      (active),
        .o_M_End       (m_end),
        .o_Instr_Start (start),
        .o_Halted      (halted),
        .o_Seq_Error   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic [3:0] s, input logic [7:0] c, input logic a,
                                       input logic me, input logic st, input logic h, input logic e);
        return {s, c, a, me, st, h, e};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later, before the next rising edge
    task automatic drive(input logic r, input logic s, input logic f, input logic h, input logic w);
        @(negedge clk);
        rst_n = r; stall = s; fetch = f; halt = h; wake = w;
        #1;
    endtask

    task automatic chk(input string name, input logic [16:0] exp);
        logic [16:0] act;
        act = {step, count, active, m_end, start, halted, err};
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got step=%b count=%b act=%b mend=%b start=%b halt=%b err=%b, want step=%b count=%b act=%b mend=%b start=%b halt=%b err=%b",
                     name, act[16:13], act[12:5], act[4], act[3], act[2], act[1], act[0],
                     exp[16:13], exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic s, input logic f, input logic [3:0] es, input logic [7:0] ec,
                       input logic me, input logic st);
        vec_t v;
        v.rst_n = 1'b1; v.stall = s; v.fetch = f; v.halt = 1'b0; v.wake = 1'b0;
        v.exp   = mk(es, ec, 1'b1, me, st, 1'b0, 1'b0);
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; stall = 1'b0; fetch = 1'b0; halt = 1'b0; wake = 1'b0;

        // 4-M-cycle instruction, fetch raised only in M4, then a 5-clock stall at T3
        add(0, 0, 4'h1, 8'h01, 0, 1);
        add(0, 0, 4'h2, 8'h01, 0, 0);
        add(0, 0, 4'h4, 8'h01, 0, 0);
        add(0, 0, 4'h8, 8'h01, 1, 0);
        for (int m = 1; m < 3; m++) begin
            add(0, 0, 4'h1, 8'h01 << m, 0, 0);
            add(0, 0, 4'h2, 8'h01 << m, 0, 0);
            add(0, 0, 4'h4, 8'h01 << m, 0, 0);
            add(0, 0, 4'h8, 8'h01 << m, 1, 0);
        end
        add(0, 1, 4'h1, 8'h08, 0, 0);
        add(0, 1, 4'h2, 8'h08, 0, 0);
        add(0, 1, 4'h4, 8'h08, 0, 0);
        add(0, 1, 4'h8, 8'h08, 1, 0);
        add(0, 0, 4'h1, 8'h01, 0, 1);
        add(0, 0, 4'h2, 8'h01, 0, 0);
        for (int k = 0; k < 5; k++) add(1, 0, 4'h4, 8'h01, 0, 0);
        add(0, 0, 4'h4, 8'h01, 0, 0);
        add(0, 0, 4'h8, 8'h01, 1, 0);
        add(0, 0, 4'h1, 8'h02, 0, 0);

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].fetch, vecs[i].halt, vecs[i].wake);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset held 3 clocks mid-instruction
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("reset", mk(4'h1, 8'h01, 1, 0, 1, 0, 0));

        // Runaway: no fetch for 32 clocks
        for (int c = 1; c < 31; c++) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("ovf_last", mk(4'h8, 8'h80, 1, 1, 0, 0, 0));
        drive(1, 0, 0, 0, 0);
        chk("ovf_recover", mk(4'h1, 8'h01, 1, 0, 1, 0, 1));
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("err_sticky", mk(4'h1, 8'h01, 1, 0, 1, 0, 1));

        // HALT entry, fetch ignored while halted, wake mid-M-cycle
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 0);
        chk("halt_req_t4", mk(4'h8, 8'h01, 1, 1, 0, 0, 1));
        drive(1, 0, 1, 0, 0);
        chk("halted", mk(4'h1, 8'h01, 0, 0, 0, 1, 1));
        drive(1, 0, 0, 0, 1);
        chk("halt_wake_mid", mk(4'h2, 8'h01, 0, 0, 0, 1, 1));
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 1, 0, 1);
        chk("halt_wake_t4", mk(4'h8, 8'h01, 0, 1, 0, 1, 1));
        drive(1, 0, 0, 0, 0);
        chk("halt_exit", mk(4'h1, 8'h01, 1, 0, 1, 0, 1));

        // Halt_Req with Wake stays in RUN
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 1);
        drive(1, 0, 0, 0, 0);
        chk("halt_wake_same", mk(4'h1, 8'h01, 1, 0, 1, 0, 1));

        // Halt_Req without fetch is ignored
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        chk("halt_no_fetch", mk(4'h1, 8'h02, 1, 0, 0, 0, 1));

        // Stall at T4 coincident with fetch; start pulse held through a stall
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        chk("stall_t4_a", mk(4'h8, 8'h02, 1, 0, 0, 0, 1));
        drive(1, 1, 1, 0, 0);
        chk("stall_t4_b", mk(4'h8, 8'h02, 1, 0, 0, 0, 1));
        drive(1, 0, 1, 0, 0);
        chk("stall_t4_release", mk(4'h8, 8'h02, 1, 1, 0, 0, 1));
        drive(1, 1, 0, 0, 0);
        chk("restart_stalled", mk(4'h1, 8'h01, 1, 0, 1, 0, 1));
        drive(1, 0, 0, 0, 0);
        chk("start_held", mk(4'h1, 8'h01, 1, 0, 1, 0, 1));
        drive(1, 0, 0, 0, 0);
        chk("start_drop", mk(4'h2, 8'h01, 1, 0, 0, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
